multicycle_ctrl: RTL and testbench

//  Main control FSM for the multicycle RV32I core. Sequences fetch, decode, execute, memory and write-back.

---
 rtl/multicycle_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Main control FSM of the multicycle RV32I core. It sequences
//                fetch/decode/exec/mem/write-back and runs a memory watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT      = 16,
    parameter bit FAULT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       br_taken,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       alu_src_b,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        c_fetch  = 3'd0,
        c_decode = 3'd1,
        c_exec   = 3'd2,
        c_mem    = 3'd3,
        c_wb     = 3'd4,
        c_fault  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        c_cls_ill    = 3'd0,
        c_cls_r      = 3'd1,
        c_cls_ialu   = 3'd2,
        c_cls_load   = 3'd3,
        c_cls_store  = 3'd4,
        c_cls_branch = 3'd5,
        c_cls_lui    = 3'd6,
        c_cls_jal    = 3'd7
    } cls_t;

    localparam logic [7:0] c_tc = 8'(MEM_TIMEOUT - 1);

    state_t     r_state, w_state_nxt;
    cls_t       r_cls, w_cls_dec;
    logic [7:0] r_cnt, w_cnt_nxt;

    logic       w_imem_req, w_dmem_req, w_dmem_we, w_ir_we, w_pc_we;
    logic [1:0] w_pc_sel, w_wb_sel;
    logic       w_alu_src_b, w_rf_we, w_fault;

    // funct3 is decoded by the ALU, not by this controller
    logic w_unused;
    assign w_unused = ^funct3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_fetch;
            r_cnt   <= '0;
            r_cls   <= c_cls_ill;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == c_decode)
                r_cls <= w_cls_dec;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_imem_req  = 1'b0;
        w_dmem_req  = 1'b0;
        w_dmem_we   = 1'b0;
        w_ir_we     = 1'b0;
        w_pc_we     = 1'b0;
        w_pc_sel    = 2'd0;
        w_alu_src_b = 1'b0;
        w_rf_we     = 1'b0;
        w_wb_sel    = 2'd0;
        w_fault     = 1'b0;

        case (opcode)
            7'b0110011: w_cls_dec = c_cls_r;
            7'b0010011: w_cls_dec = c_cls_ialu;
            7'b0000011: w_cls_dec = c_cls_load;
            7'b0100011: w_cls_dec = c_cls_store;
            7'b1100011: w_cls_dec = c_cls_branch;
            7'b0110111: w_cls_dec = c_cls_lui;
            7'b1101111: w_cls_dec = c_cls_jal;
            default:    w_cls_dec = c_cls_ill;
        endcase

        case (r_state)
            c_fetch: begin
                w_imem_req = 1'b1;
                if (imem_ready) begin
                    w_ir_we     = 1'b1;
                    w_state_nxt = c_decode;
                end else if (r_cnt == c_tc) begin
                    w_state_nxt = c_fault;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            c_decode: begin
                if (w_cls_dec == c_cls_ill)
                    w_state_nxt = FAULT_ON_ILLEGAL ? c_fault : c_wb;
                else
                    w_state_nxt = c_exec;
            end
            c_exec: begin
                w_alu_src_b = (r_cls == c_cls_ialu) || (r_cls == c_cls_load) ||
                              (r_cls == c_cls_store);
                if (r_cls == c_cls_branch) begin
                    w_pc_we     = 1'b1;
                    w_pc_sel    = br_taken ? 2'd1 : 2'd0;
                    w_state_nxt = c_fetch;
                end else if ((r_cls == c_cls_load) || (r_cls == c_cls_store)) begin
                    w_state_nxt = c_mem;
                end else begin
                    w_state_nxt = c_wb;
                end
            end
            c_mem: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (r_cls == c_cls_store);
                if (dmem_ready) begin
                    // stores retire here; loads still need the register write
                    if (r_cls == c_cls_store) begin
                        w_pc_we     = 1'b1;
                        w_state_nxt = c_fetch;
                    end else begin
                        w_state_nxt = c_wb;
                    end
                end else if (r_cnt == c_tc) begin
                    w_state_nxt = c_fault;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            c_wb: begin
                w_pc_we     = 1'b1;
                w_pc_sel    = (r_cls == c_cls_jal) ? 2'd2 : 2'd0;
                w_rf_we     = (r_cls == c_cls_r) || (r_cls == c_cls_ialu) ||
                              (r_cls == c_cls_load) || (r_cls == c_cls_lui) ||
                              (r_cls == c_cls_jal);
                case (r_cls)
                    c_cls_load: w_wb_sel = 2'd1;
                    c_cls_lui:  w_wb_sel = 2'd2;
                    c_cls_jal:  w_wb_sel = 2'd3;
                    default:    w_wb_sel = 2'd0;
                endcase
                w_state_nxt = c_fetch;
            end
            default: begin
                // FAULT and the unused encodings all park in FAULT
                w_fault     = 1'b1;
                w_state_nxt = c_fault;
            end
        endcase
    end

    // Everything reads zero while reset is held, including mid-access
    assign imem_req  = w_imem_req  & ~rst;
    assign dmem_req  = w_dmem_req  & ~rst;
    assign dmem_we   = w_dmem_we   & ~rst;
    assign ir_we     = w_ir_we     & ~rst;
    assign pc_we     = w_pc_we     & ~rst;
    assign pc_sel    = rst ? 2'd0 : w_pc_sel;
    assign alu_src_b = w_alu_src_b & ~rst;
    assign rf_we     = w_rf_we     & ~rst;
    assign wb_sel    = rst ? 2'd0 : w_wb_sel;
    assign fault     = w_fault     & ~rst;
    assign state     = rst ? 3'd0 : r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Scoreboard bench for multicycle_ctrl; per-cycle expected
//                control vectors are queued by stimulus and popped by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam logic [6:0] c_op_r   = 7'b0110011;
    localparam logic [6:0] c_op_i   = 7'b0010011;
    localparam logic [6:0] c_op_ld  = 7'b0000011;
    localparam logic [6:0] c_op_st  = 7'b0100011;
    localparam logic [6:0] c_op_br  = 7'b1100011;
    localparam logic [6:0] c_op_lui = 7'b0110111;
    localparam logic [6:0] c_op_jal = 7'b1101111;
    localparam logic [6:0] c_op_ill = 7'b1111111;

    typedef struct {
        string       name;
        logic [14:0] exp;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: MEM_TIMEOUT=4, illegal opcode faults
    logic       a_rst = 1'b1, a_br = 1'b0, a_imr = 1'b0, a_dmr = 1'b0;
    logic [6:0] a_op = '0;
    logic [2:0] a_f3 = '0;
    logic       a_ireq, a_dreq, a_dwe, a_irwe, a_pcwe, a_asb, a_rfwe, a_fault;
    logic [1:0] a_psel, a_wbs;
    logic [2:0] a_state;

    // instance B: default MEM_TIMEOUT, illegal opcode treated as NOP
    logic       b_rst = 1'b1, b_br = 1'b0, b_imr = 1'b0, b_dmr = 1'b0;
    logic [6:0] b_op = '0;
    logic [2:0] b_f3 = '0;
    logic       b_ireq, b_dreq, b_dwe, b_irwe, b_pcwe, b_asb, b_rfwe, b_fault;
    logic [1:0] b_psel, b_wbs;
    logic [2:0] b_state;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .FAULT_ON_ILLEGAL(1'b1)) dut_a (
        .clk(clk), .rst(a_rst), .opcode(a_op), .funct3(a_f3), .br_taken(a_br),
        .imem_ready(a_imr), .dmem_ready(a_dmr), .imem_req(a_ireq), .dmem_req(a_dreq),
        .dmem_we(a_dwe), .ir_we(a_irwe), .pc_we(a_pcwe), .pc_sel(a_psel),
        .alu_src_b(a_asb), .rf_we(a_rfwe), .wb_sel(a_wbs), .fault(a_fault),
        .state(a_state)
    );

    multicycle_ctrl #(.MEM_TIMEOUT(16), .FAULT_ON_ILLEGAL(1'b0)) dut_b (
        .clk(clk), .rst(b_rst), .opcode(b_op), .funct3(b_f3), .br_taken(b_br),
        .imem_ready(b_imr), .dmem_ready(b_dmr), .imem_req(b_ireq), .dmem_req(b_dreq),
        .dmem_we(b_dwe), .ir_we(b_irwe), .pc_we(b_pcwe), .pc_sel(b_psel),
        .alu_src_b(b_asb), .rf_we(b_rfwe), .wb_sel(b_wbs), .fault(b_fault),
        .state(b_state)
    );

    // {state, fault, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_src_b, rf_we, wb_sel}
    logic [14:0] a_vec, b_vec;
    assign a_vec = {a_state, a_fault, a_ireq, a_dreq, a_dwe, a_irwe, a_pcwe, a_psel, a_asb, a_rfwe, a_wbs};
    assign b_vec = {b_state, b_fault, b_ireq, b_dreq, b_dwe, b_irwe, b_pcwe, b_psel, b_asb, b_rfwe, b_wbs};

    item_t qa[$];
    item_t qb[$];
    int    checks = 0;
    int    errors = 0;

    function automatic logic [14:0] ev(input logic [2:0] st, input logic f, ireq, dreq, dwe,
                                       irwe, pcwe, input logic [1:0] psel, input logic asb,
                                       rfwe, input logic [1:0] wbs);
        return {st, f, ireq, dreq, dwe, irwe, pcwe, psel, asb, rfwe, wbs};
    endfunction

    function automatic logic [14:0] e_fetch(input logic irwe);
        return ev(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, irwe, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    endfunction
    function automatic logic [14:0] e_dec();
        return ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    endfunction
    function automatic logic [14:0] e_exec(input logic asb, pcwe, input logic [1:0] psel);
        return ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pcwe, psel, asb, 1'b0, 2'd0);
    endfunction
    function automatic logic [14:0] e_mem(input logic dwe, pcwe);
        return ev(3'd3, 1'b0, 1'b0, 1'b1, dwe, 1'b0, pcwe, 2'd0, 1'b0, 1'b0, 2'd0);
    endfunction
    function automatic logic [14:0] e_wb(input logic [1:0] psel, input logic rfwe,
                                         input logic [1:0] wbs);
        return ev(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, psel, 1'b0, rfwe, wbs);
    endfunction
    function automatic logic [14:0] e_fault();
        return ev(3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    endfunction

    // Inputs applied 1 ns after the edge; expectation covers this cycle
    task automatic cyc_a(input string name, input logic r, input logic [6:0] op,
                         input logic br, imr, dmr, input logic [14:0] exp);
        a_rst = r; a_op = op; a_br = br; a_imr = imr; a_dmr = dmr;
        qa.push_back('{name, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_b(input string name, input logic r, input logic [6:0] op,
                         input logic imr, input logic [14:0] exp);
        b_rst = r; b_op = op; b_imr = imr;
        qb.push_back('{name, exp});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        item_t it;
        if (qa.size() > 0) begin
            it = qa.pop_front();
            checks++;
            if (a_vec !== it.exp) begin
                errors++;
                $display("FAIL a.%s: got %h expected %h", it.name, a_vec, it.exp);
            end
        end
    end

    always @(negedge clk) begin
        item_t it;
        if (qb.size() > 0) begin
            it = qb.pop_front();
            checks++;
            if (b_vec !== it.exp) begin
                errors++;
                $display("FAIL b.%s: got %h expected %h", it.name, b_vec, it.exp);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        cyc_a("reset0", 1, c_op_r, 0, 1, 1, '0);
        cyc_a("reset1", 1, c_op_r, 0, 1, 1, '0);
        // opcode is driven illegal outside DECODE to show it is ignored there
        cyc_a("r_fetch", 0, c_op_ill, 0, 1, 0, e_fetch(1));
        cyc_a("r_dec",   0, c_op_r,   0, 0, 0, e_dec());
        cyc_a("r_exec",  0, c_op_ill, 0, 0, 0, e_exec(0, 0, 2'd0));
        cyc_a("r_wb",    0, c_op_ill, 0, 0, 0, e_wb(2'd0, 1, 2'd0));
        cyc_a("i_fetch", 0, c_op_ill, 0, 1, 0, e_fetch(1));
        cyc_a("i_dec",   0, c_op_i,   0, 0, 0, e_dec());
        cyc_a("i_exec",  0, c_op_ill, 0, 0, 0, e_exec(1, 0, 2'd0));
        cyc_a("i_wb",    0, c_op_ill, 0, 0, 0, e_wb(2'd0, 1, 2'd0));
        cyc_a("ld_fetch", 0, c_op_ill, 0, 1, 0, e_fetch(1));
        cyc_a("ld_dec",   0, c_op_ld,  0, 0, 0, e_dec());
        cyc_a("ld_exec",  0, c_op_ill, 0, 0, 0, e_exec(1, 0, 2'd0));
        for (int i = 0; i < 3; i++)
            cyc_a("ld_memwait", 0, c_op_ill, 0, 0, 0, e_mem(0, 0));
        cyc_a("ld_memrdy", 0, c_op_ill, 0, 0, 1, e_mem(0, 0));
        cyc_a("ld_wb",     0, c_op_ill, 0, 0, 0, e_wb(2'd0, 1, 2'd1));
        cyc_a("lui_fetch", 0, c_op_ill, 0, 1, 0, e_fetch(1));
        cyc_a("lui_dec",   0, c_op_lui, 0, 0, 0, e_dec());
        cyc_a("lui_exec",  0, c_op_ill, 0, 0, 0, e_exec(0, 0, 2'd0));
        cyc_a("lui_wb",    0, c_op_ill, 0, 0, 0, e_wb(2'd0, 1, 2'd2));
        cyc_a("jal_fetch", 0, c_op_ill, 0, 1, 0, e_fetch(1));
        cyc_a("jal_dec",   0, c_op_jal, 0, 0, 0, e_dec());
        cyc_a("jal_exec",  0, c_op_ill, 0, 0, 0, e_exec(0, 0, 2'd0));
        cyc_a("jal_wb",    0, c_op_ill, 0, 0, 0, e_wb(2'd2, 1, 2'd3));
        cyc_a("bt_fetch",  0, c_op_ill, 0, 1, 0, e_fetch(1));
        cyc_a("bt_dec",    0, c_op_br,  0, 0, 0, e_dec());
        cyc_a("bt_exec",   0, c_op_ill, 1, 0, 0, e_exec(0, 1, 2'd1));
        cyc_a("bn_fetch",  0, c_op_ill, 0, 1, 0, e_fetch(1));
        cyc_a("bn_dec",    0, c_op_br,  0, 0, 0, e_dec());
        cyc_a("bn_exec",   0, c_op_ill, 0, 0, 0, e_exec(0, 1, 2'd0));
        // ready arrives exactly at the terminal count and must be accepted
        for (int i = 0; i < 3; i++)
            cyc_a("st_fwait", 0, c_op_ill, 0, 0, 0, e_fetch(0));
        cyc_a("st_ftc",   0, c_op_ill, 0, 1, 0, e_fetch(1));
        cyc_a("st_dec",   0, c_op_st,  0, 0, 0, e_dec());
        cyc_a("st_exec",  0, c_op_ill, 0, 0, 0, e_exec(1, 0, 2'd0));
        cyc_a("st_mem",   0, c_op_ill, 0, 0, 1, e_mem(1, 1));
        // store whose data memory never answers: faults after 4 MEM cycles
        cyc_a("sto_fetch", 0, c_op_ill, 0, 1, 0, e_fetch(1));
        cyc_a("sto_dec",   0, c_op_st,  0, 0, 0, e_dec());
        cyc_a("sto_exec",  0, c_op_ill, 0, 0, 0, e_exec(1, 0, 2'd0));
        for (int i = 0; i < 4; i++)
            cyc_a("sto_memwait", 0, c_op_ill, 0, 0, 0, e_mem(1, 0));
        cyc_a("sto_fault0", 0, c_op_ill, 0, 1, 1, e_fault());
        cyc_a("sto_fault1", 0, c_op_ill, 0, 1, 1, e_fault());
        cyc_a("sto_rst",    1, c_op_ill, 0, 1, 1, '0);
        // reset in the middle of a store access
        cyc_a("sr_fetch", 0, c_op_ill, 0, 1, 0, e_fetch(1));
        cyc_a("sr_dec",   0, c_op_st,  0, 0, 0, e_dec());
        cyc_a("sr_exec",  0, c_op_ill, 0, 0, 0, e_exec(1, 0, 2'd0));
        cyc_a("sr_mem",   0, c_op_ill, 0, 0, 0, e_mem(1, 0));
        cyc_a("sr_rst",   1, c_op_ill, 0, 0, 1, '0);
        // fetch watchdog: 4 unanswered FETCH cycles then sticky FAULT
        for (int i = 0; i < 4; i++)
            cyc_a("wd_fetch", 0, c_op_ill, 0, 0, 0, e_fetch(0));
        cyc_a("wd_fault0", 0, c_op_r, 0, 1, 1, e_fault());
        cyc_a("wd_fault1", 0, c_op_r, 0, 1, 1, e_fault());
        cyc_a("wd_rst",    1, c_op_r, 0, 1, 1, '0);
        cyc_a("ill_fetch", 0, c_op_ill, 0, 1, 0, e_fetch(1));
        cyc_a("ill_dec",   0, c_op_ill, 0, 0, 0, e_dec());
        cyc_a("ill_fault", 0, c_op_r,   0, 1, 0, e_fault());
        cyc_a("ill_rst",   1, c_op_r,   0, 0, 0, '0);
        cyc_a("post_fetch", 0, c_op_r,  0, 0, 0, e_fetch(0));

        cyc_b("b_reset",  1, c_op_ill, 1, '0);
        cyc_b("b_fetch",  0, c_op_r,   1, e_fetch(1));
        cyc_b("b_dec",    0, c_op_ill, 0, e_dec());
        cyc_b("b_wb",     0, c_op_ill, 0, e_wb(2'd0, 0, 2'd0));
        for (int i = 0; i < 5; i++)
            cyc_b("b_fwait", 0, c_op_ill, 0, e_fetch(0));
        cyc_b("b_fetch2", 0, c_op_r,   1, e_fetch(1));
        cyc_b("b_dec2",   0, c_op_lui, 0, e_dec());

        for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++)
            @(posedge clk);
        if (qa.size() > 0 || qb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", qa.size() + qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
